// File: rtl/n_term_tile_gen.sv
// North-terminating fabric tile: turns N-arriving wire groups back south under per-group
// mode control, and re-times the FrameData/FrameStrobe chain. Optional macro FRAME_PARITY_EN.

module n_term_turn_lane #(
  parameter int W = 4
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic [1:0]   mode_i,
  input  logic [W-1:0] src_i,
  output logic [W-1:0] dst_o
);
  logic [W-1:0] hold_q;
  logic [W-1:0] rev;

  // Free-running so a switch into registered mode shows a live value with no bubble.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) hold_q <= '0;
    else         hold_q <= src_i;
  end

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign rev[i] = src_i[W-1-i];
  end

  always_comb begin
    dst_o = src_i;
    case (mode_i)
      2'b01:   dst_o = hold_q;
      2'b10:   dst_o = rev;
      2'b11:   dst_o = '0;
      default: dst_o = src_i;
    endcase
  end
endmodule

module n_term_tile_gen #(
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int PIPE_STAGES        = 1,
  parameter int W1                 = 4,
  parameter int W2                 = 8,
  parameter int W4                 = 16
) (
  input  logic                          UserCLK,
  input  logic                          resetn,
  input  logic [W1-1:0]                 N1END,
  input  logic [W2-1:0]                 N2MID,
  input  logic [W2-1:0]                 N2END,
  input  logic [W4-1:0]                 N4END,
  input  logic [W4-1:0]                 NN4END,
  output logic [W1-1:0]                 S1BEG,
  output logic [W2-1:0]                 S2BEG,
  output logic [W2-1:0]                 S2BEGb,
  output logic [W4-1:0]                 S4BEG,
  output logic [W4-1:0]                 SS4BEG,
  input  logic [FRAME_BITS_PER_ROW-1:0] FrameData,
  output logic [FRAME_BITS_PER_ROW-1:0] FrameData_O,
  input  logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
  output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe_O,
  output logic                          cfg_valid,
  output logic                          cfg_err
);
  localparam int CW = FRAME_BITS_PER_ROW + MAX_FRAMES_PER_COL;

  logic [CW-1:0] chain_in, chain_out;
  assign chain_in = {FrameStrobe, FrameData};

  if (PIPE_STAGES == 0) begin : g_wire
    assign chain_out = chain_in;
  end else begin : g_pipe
    logic [PIPE_STAGES-1:0][CW-1:0] pipe_q;
    always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) pipe_q <= '0;
      else begin
        pipe_q[0] <= chain_in;
        for (int s = 1; s < PIPE_STAGES; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end
    assign chain_out = pipe_q[PIPE_STAGES-1];
  end

  assign FrameData_O   = chain_out[FRAME_BITS_PER_ROW-1:0];
  assign FrameStrobe_O = chain_out[CW-1:FRAME_BITS_PER_ROW];

  logic       strobe_q, cap, par_ok;
  logic [9:0] cfg_q, cfg_d;
  logic       valid_q, valid_d;

  // Local capture looks at the undelayed strobe; only bit 0 belongs to this tile.
  assign cap = FrameStrobe[0] & ~strobe_q;

`ifdef FRAME_PARITY_EN
  logic err_q, err_d;
  assign par_ok  = (FrameData[FRAME_BITS_PER_ROW-1] == ^FrameData[9:0]);
  assign err_d   = err_q | (cap & ~par_ok);
  assign cfg_err = err_q;
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  assign par_ok  = 1'b1;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    cfg_d   = cfg_q;
    valid_d = valid_q;
    if (cap && par_ok) begin
      cfg_d   = FrameData[9:0];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      strobe_q <= 1'b0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      strobe_q <= FrameStrobe[0];
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
    end
  end

  assign cfg_valid = valid_q;

  for (genvar g = 0; g < 5; g++) begin : g_lane
    if (g == 0) begin : g_s1
      n_term_turn_lane #(.W(W1)) u_lane (.gclk(UserCLK), .grst_n(resetn),
        .mode_i(cfg_q[2*g+1:2*g]), .src_i(N1END), .dst_o(S1BEG));
    end else if (g == 1) begin : g_s2
      n_term_turn_lane #(.W(W2)) u_lane (.gclk(UserCLK), .grst_n(resetn),
        .mode_i(cfg_q[2*g+1:2*g]), .src_i(N2MID), .dst_o(S2BEG));
    end else if (g == 2) begin : g_s2b
      n_term_turn_lane #(.W(W2)) u_lane (.gclk(UserCLK), .grst_n(resetn),
        .mode_i(cfg_q[2*g+1:2*g]), .src_i(N2END), .dst_o(S2BEGb));
    end else if (g == 3) begin : g_s4
      n_term_turn_lane #(.W(W4)) u_lane (.gclk(UserCLK), .grst_n(resetn),
        .mode_i(cfg_q[2*g+1:2*g]), .src_i(N4END), .dst_o(S4BEG));
    end else begin : g_ss4
      n_term_turn_lane #(.W(W4)) u_lane (.gclk(UserCLK), .grst_n(resetn),
        .mode_i(cfg_q[2*g+1:2*g]), .src_i(NN4END), .dst_o(SS4BEG));
    end
  end
endmodule

// File: tb/tb_n_term_tile_gen.sv
// Bench for n_term_tile_gen: a history-based model checked every cycle, plus directed
// vectors with literal expectations. Three instances cover chain depths 0, 1 and 4.

module tb_n_term_tile_gen;
  logic        UserCLK = 1'b0;
  logic        resetn;
  logic [3:0]  N1END;
  logic [7:0]  N2MID, N2END;
  logic [15:0] N4END, NN4END;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;

  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG, S2BEGb;
  logic [15:0] S4BEG, SS4BEG;
  logic [31:0] fdo1, fdo0, fdo4;
  logic [19:0] fso1, fso0, fso4;
  logic        cfg_valid, cfg_err;
  logic [3:0]  x1_0, x1_4;
  logic [7:0]  x2_0, x2_4, x2b_0, x2b_4;
  logic [15:0] x4_0, x4_4, xx4_0, xx4_4;
  logic        xv0, xv4, xe0, xe4;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 UserCLK = ~UserCLK;

  n_term_tile_gen #(.PIPE_STAGES(1)) u_p1 (
    .UserCLK(UserCLK), .resetn(resetn), .N1END(N1END), .N2MID(N2MID), .N2END(N2END),
    .N4END(N4END), .NN4END(NN4END), .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb),
    .S4BEG(S4BEG), .SS4BEG(SS4BEG), .FrameData(FrameData), .FrameData_O(fdo1),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(fso1), .cfg_valid(cfg_valid), .cfg_err(cfg_err));

  n_term_tile_gen #(.PIPE_STAGES(0)) u_p0 (
    .UserCLK(UserCLK), .resetn(resetn), .N1END(N1END), .N2MID(N2MID), .N2END(N2END),
    .N4END(N4END), .NN4END(NN4END), .S1BEG(x1_0), .S2BEG(x2_0), .S2BEGb(x2b_0),
    .S4BEG(x4_0), .SS4BEG(xx4_0), .FrameData(FrameData), .FrameData_O(fdo0),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(fso0), .cfg_valid(xv0), .cfg_err(xe0));

  n_term_tile_gen #(.PIPE_STAGES(4)) u_p4 (
    .UserCLK(UserCLK), .resetn(resetn), .N1END(N1END), .N2MID(N2MID), .N2END(N2END),
    .N4END(N4END), .NN4END(NN4END), .S1BEG(x1_4), .S2BEG(x2_4), .S2BEGb(x2b_4),
    .S4BEG(x4_4), .SS4BEG(xx4_4), .FrameData(FrameData), .FrameData_O(fdo4),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(fso4), .cfg_valid(xv4), .cfg_err(xe4));

  // Model state: captured config, flags, previous strobe, last-cycle sources, chain history.
  logic [9:0]  m_cfg = '0;
  logic        m_valid = 1'b0, m_err = 1'b0, m_sprev = 1'b0;
  logic [15:0] m_prev [5];
  logic [51:0] m_hist [4];

  initial begin
    for (int i = 0; i < 5; i++) m_prev[i] = '0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  end

  always @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      m_cfg = '0; m_valid = 1'b0; m_err = 1'b0; m_sprev = 1'b0;
      for (int i = 0; i < 5; i++) m_prev[i] = '0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
    end else begin
      if (FrameStrobe[0] && !m_sprev) begin
`ifdef FRAME_PARITY_EN
        if (FrameData[31] != ^FrameData[9:0]) m_err = 1'b1;
        else begin m_cfg = FrameData[9:0]; m_valid = 1'b1; end
`else
        m_cfg = FrameData[9:0]; m_valid = 1'b1;
`endif
      end
      m_sprev = FrameStrobe[0];
      m_prev[0] = {12'b0, N1END};  m_prev[1] = {8'b0, N2MID}; m_prev[2] = {8'b0, N2END};
      m_prev[3] = N4END;           m_prev[4] = NN4END;
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = {FrameStrobe, FrameData};
    end
  end

  function automatic logic [15:0] turn(input logic [1:0] m, input logic [15:0] s,
                                       input logic [15:0] p, input int w);
    logic [15:0] r;
    r = '0;
    case (m)
      2'b00: r = s;
      2'b01: r = p;
      2'b10: for (int i = 0; i < w; i++) r[i] = s[w-1-i];
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [51:0] chain_exp(input int k);
    if (k == 0) return {FrameStrobe, FrameData};
    return m_hist[k-1];
  endfunction

  function automatic logic [31:0] frame(input logic [9:0] c);
    return {^c, 21'b0, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge UserCLK) begin
    if (chk_en) begin
      chk("m_s1",   S1BEG,  turn(m_cfg[1:0], {12'b0, N1END}, m_prev[0], 4));
      chk("m_s2",   S2BEG,  turn(m_cfg[3:2], {8'b0, N2MID},  m_prev[1], 8));
      chk("m_s2b",  S2BEGb, turn(m_cfg[5:4], {8'b0, N2END},  m_prev[2], 8));
      chk("m_s4",   S4BEG,  turn(m_cfg[7:6], N4END,          m_prev[3], 16));
      chk("m_ss4",  SS4BEG, turn(m_cfg[9:8], NN4END,         m_prev[4], 16));
      chk("m_valid", cfg_valid, m_valid);
      chk("m_err",   cfg_err,   m_err);
      chk("m_chain1", {fso1, fdo1}, chain_exp(1));
      chk("m_chain0", {fso0, fdo0}, chain_exp(0));
      chk("m_chain4", {fso4, fdo4}, chain_exp(4));
    end
  end

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic rnd_src();
    N1END = 4'($urandom); N2MID = 8'($urandom); N2END = 8'($urandom);
    N4END = 16'($urandom); NN4END = 16'($urandom);
  endtask

  initial begin
    resetn = 1'b0; N1END = '0; N2MID = '0; N2END = '0; N4END = '0; NN4END = '0;
    FrameData = '0; FrameStrobe = '0;
    chk_en = 1'b1;
    repeat (2) step();
    chk("rst_valid", cfg_valid, 1'b0);
    chk("rst_err",   cfg_err,   1'b0);
    chk("rst_fdo1",  fdo1,      32'h0);

    resetn = 1'b1; N1END = 4'b1010;
    #1 chk("rst_direct", S1BEG, 4'b1010);

    // Chain latency, strobe on bit 1 only (pass-through, no capture).
    step(); FrameData = 32'hA5A5_0001; FrameStrobe = 20'h00002;
    #1 chk("lat0_fd", fdo0, 32'hA5A5_0001);
    chk("lat0_fs", fso0, 20'h00002);
    step(); FrameData = '0; FrameStrobe = '0;
    chk("lat1_fd", fdo1, 32'hA5A5_0001);
    chk("lat1_fs", fso1, 20'h00002);
    step(); step();
    chk("lat4_early", fdo4, 32'h0);
    step();
    chk("lat4_fd", fdo4, 32'hA5A5_0001);
    chk("lat4_fs", fso4, 20'h00002);
    chk("no_cap_bit1", cfg_valid, 1'b0);

    // Capture g0=reg g1=direct g2=rev g3=tie0 g4=reg; data changes mid-strobe.
    step(); FrameData = frame(10'b01_11_10_00_01); FrameStrobe = 20'h1;
    step(); FrameData = frame(10'h0);
    chk("cap_valid", cfg_valid, 1'b1);
    step(); step(); FrameStrobe = '0;
    N2END = 8'h01; N2MID = 8'h5A; N4END = 16'hBEEF; N1END = 4'h3; NN4END = 16'h1234;
    #1 chk("rev_s2b", S2BEGb, 8'h80);
    chk("dir_s2", S2BEG, 8'h5A);
    chk("tie0_s4", S4BEG, 16'h0);
    step(); N1END = 4'hC; NN4END = 16'hFFFF;
    #1 chk("reg_s1", S1BEG, 4'h3);
    chk("reg_ss4", SS4BEG, 16'h1234);

    repeat (8) begin step(); rnd_src(); end

    // Re-capture with cfg=0 -> all direct from the next cycle.
    step(); FrameStrobe = 20'h1; FrameData = frame(10'h0);
    step(); FrameStrobe = '0; N1END = 4'h6; N4END = 16'hBEEF;
    #1 chk("recap_s1", S1BEG, 4'h6);
    chk("recap_s4", S4BEG, 16'hBEEF);

    // Reset while registered modes active, with strobe held across release.
    step(); FrameStrobe = 20'h1; FrameData = frame(10'b01_11_10_00_01);
    step(); FrameStrobe = '0;
    repeat (3) begin step(); rnd_src(); end
    N1END = 4'h9;
    resetn = 1'b0; FrameStrobe = 20'h1;
    #1 chk("midrst_s1", S1BEG, 4'h9);
    chk("midrst_valid", cfg_valid, 1'b0);
    step(); step(); resetn = 1'b1;
    step(); FrameStrobe = '0;
    chk("rel_cap_valid", cfg_valid, 1'b1);
    N4END = 16'h7777;
    #1 chk("rel_cap_tie0", S4BEG, 16'h0);

`ifdef FRAME_PARITY_EN
    step(); FrameStrobe = 20'h1; FrameData = frame(10'h0) ^ 32'h8000_0000;
    step(); FrameStrobe = '0;
    chk("par_err", cfg_err, 1'b1);
    chk("par_keep", S4BEG, 16'h0);
    step(); FrameStrobe = 20'h1; FrameData = frame(10'h0);
    step(); FrameStrobe = '0;
    chk("par_good_cap", S4BEG, N4END);
    chk("par_sticky", cfg_err, 1'b1);
`else
    step(); FrameStrobe = 20'h1; FrameData = frame(10'h0) ^ 32'h8000_0000;
    step(); FrameStrobe = '0;
    chk("nopar_err", cfg_err, 1'b0);
    chk("nopar_cap", S4BEG, N4END);
`endif

    repeat (4) begin step(); rnd_src(); end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
